// File: rtl/side_ch_s_axis_gen_if.sv
// AXI-Stream bundle carrying side-channel DMA beats from the PS into side_ch_s_axis_gen.
interface side_ch_s_axis_gen_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 64
);
  logic                              tready;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] tstrb;
  logic                              tlast;
  logic                              tvalid;

  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/side_ch_s_axis_gen.sv
// AXI-Stream side-channel receiver: burst control FSM (count/endless/TLAST/count-or-TLAST)
// feeding an inferred FIFO that the PL drains with a one-cycle registered read.
module side_ch_s_axis_gen #(
  parameter int C_S_AXIS_TDATA_WIDTH   = 64,
  parameter int FIFO_DEPTH_LOG2        = 9,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [1:0]                        s_axis_mode,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] S_AXIS_NUM_DMA_SYMBOL,
  input  logic                              s_axis_flush,
  output logic [1:0]                        s_axis_state,
  output logic                              s_axis_burst_done,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] s_axis_burst_len,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_to_pl,
  input  logic                              pl_ask_data,
  output logic                              data_valid_to_pl,
  output logic [FIFO_DEPTH_LOG2:0]          s_axis_data_count,
  output logic                              emptyn_to_pl,
  output logic                              fifo_full,
  side_ch_s_axis_gen_if.slave               s_axis
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]          FULL_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] CNT_ONE  = MAX_BIT_NUM_DMA_SYMBOL'(1);
  localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                              state, state_nx;
  logic [1:0]                          mode_q;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_q, beat_cnt, beat_cnt_inc;
  logic                                beat, terminate, push, pop;
  logic [FIFO_DEPTH_LOG2-1:0]          wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]            count_nx;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]     mem [DEPTH];
  logic                                unused_tstrb;

  // Strobes are ignored: only full beats are ever sent by the DMA.
  assign unused_tstrb = ^s_axis.tstrb;

  // TREADY depends on registered state only, never on TVALID.
  assign s_axis.tready     = (state == ST_WRITE) && !fifo_full;
  assign beat              = s_axis.tvalid && s_axis.tready;
  assign push              = beat && !s_axis_flush;
  assign pop               = pl_ask_data && emptyn_to_pl && !s_axis_flush;
  assign beat_cnt_inc      = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_ONE;
  assign s_axis_state      = state;
  assign s_axis_burst_done = (state == ST_DONE);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    terminate = 1'b0;
    case (mode_q)
      2'd0:    terminate = (beat_cnt == num_q - CNT_ONE);
      2'd2:    terminate = s_axis.tlast;
      2'd3:    terminate = (beat_cnt == num_q - CNT_ONE) || s_axis.tlast;
      default: terminate = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (s_axis.tvalid && !(s_axis_mode == 2'd0 && S_AXIS_NUM_DMA_SYMBOL == '0))
                  state_nx = ST_WRITE;
      ST_WRITE: if (beat && terminate) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
    if (s_axis_flush) state_nx = ST_FLUSH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) state <= ST_IDLE;
    else               state <= state_nx;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      mode_q           <= 2'd0;
      num_q            <= '0;
      beat_cnt         <= '0;
      s_axis_burst_len <= '0;
    end else if (s_axis_flush) begin
      beat_cnt <= '0;
    end else if (state == ST_IDLE && state_nx == ST_WRITE) begin
      mode_q   <= s_axis_mode;
      num_q    <= S_AXIS_NUM_DMA_SYMBOL;
      beat_cnt <= '0;
    end else if (state == ST_WRITE && beat) begin
      beat_cnt <= beat_cnt_inc;
      if (terminate) s_axis_burst_len <= beat_cnt_inc;
    end
  end

  always_comb begin
    count_nx = s_axis_data_count;
    case ({push, pop})
      2'b10:   count_nx = s_axis_data_count + 1'b1;
      2'b01:   count_nx = s_axis_data_count - 1'b1;
      default: count_nx = s_axis_data_count;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      s_axis_data_count <= '0;
      fifo_full         <= 1'b0;
      emptyn_to_pl      <= 1'b0;
      data_valid_to_pl  <= 1'b0;
      data_to_pl        <= '0;
    end else if (s_axis_flush) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      s_axis_data_count <= '0;
      fifo_full         <= 1'b0;
      emptyn_to_pl      <= 1'b0;
      data_valid_to_pl  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_to_pl <= mem[rd_ptr];
      end
      data_valid_to_pl  <= pop;
      s_axis_data_count <= count_nx;
      fifo_full         <= (count_nx == FULL_CNT);
      emptyn_to_pl      <= (count_nx != '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define its contents.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) mem[wr_ptr] <= s_axis.tdata;
  end

endmodule

// File: tb/tb_side_ch_s_axis_gen.sv
// Self-checking bench for side_ch_s_axis_gen: queue-based burst/FIFO model, vector table,
// hand sequences for full/read/flush/reset corners, then randomized traffic.
module tb_side_ch_s_axis_gen;
  localparam int W = 64, L = 9, M = 14, DEPTH = 512, MAXC = (1 << M) - 1;

  logic clk = 1'b0;
  logic rst, flush, ask;
  logic [1:0] mode;
  logic [M-1:0] num;
  logic [1:0] st;
  logic done, valid, emptyn, full;
  logic [M-1:0] blen;
  logic [W-1:0] dout;
  logic [L:0] cnt;

  always #5 clk = ~clk;

  side_ch_s_axis_gen_if #(.C_S_AXIS_TDATA_WIDTH(W)) axis ();

  side_ch_s_axis_gen #(
    .C_S_AXIS_TDATA_WIDTH(W), .FIFO_DEPTH_LOG2(L), .MAX_BIT_NUM_DMA_SYMBOL(M)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .s_axis_mode(mode), .S_AXIS_NUM_DMA_SYMBOL(num),
    .s_axis_flush(flush), .s_axis_state(st), .s_axis_burst_done(done), .s_axis_burst_len(blen),
    .data_to_pl(dout), .pl_ask_data(ask), .data_valid_to_pl(valid), .s_axis_data_count(cnt),
    .emptyn_to_pl(emptyn), .fifo_full(full), .s_axis(axis.slave)
  );

  int checks = 0, failures = 0;
  logic [W-1:0] next_data = 64'h100;

  // Behavioural model: burst phase, beats in burst, FIFO contents as a queue.
  int m_state = 0, m_beats = 0, m_mode = 0, m_num = 0, m_len = 0;
  bit m_valid = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit tr, push, pop, term;
    tr = (m_state == 1) && (m_q.size() < DEPTH);
    check("tready", axis.tready, tr);
    push = axis.tvalid && tr;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_q.delete(); m_beats = 0; m_mode = 0; m_num = 0;
      m_len = 0; m_valid = 0; m_data = '0;
    end else if (flush) begin
      m_state = 3; m_q.delete(); m_beats = 0; m_valid = 0;
    end else begin
      pop = ask && (m_q.size() > 0);
      m_valid = pop;
      if (pop) m_data = m_q.pop_front();
      if (push) m_q.push_back(axis.tdata);
      case (m_state)
        0: if (axis.tvalid && !(mode == 0 && num == 0)) begin
             m_state = 1; m_mode = int'(mode); m_num = int'(num); m_beats = 0;
           end
        1: if (push) begin
             if (m_beats < MAXC) m_beats++;
             term = ((m_mode == 2 || m_mode == 3) && axis.tlast) ||
                    ((m_mode == 0 || m_mode == 3) && m_beats == m_num);
             if (term) begin m_len = m_beats; m_state = 2; end
           end
        default: m_state = 0;
      endcase
    end
    #1;
    check("state", st, m_state);
    check("burst_done", done, m_state == 2);
    check("burst_len", blen, m_len);
    check("data_count", cnt, m_q.size());
    check("emptyn", emptyn, m_q.size() != 0);
    check("fifo_full", full, m_q.size() == DEPTH);
    check("data_valid", valid, m_valid);
    check("data_to_pl", dout, m_data);
  endtask

  // Offers up to n beats (holding each until accepted), stops offering once DONE is seen.
  task automatic offer(input int n, input int last_at, output int acc);
    int i = 0, budget = 0;
    bit hs;
    acc = 0;
    axis.tvalid = 1'b1; axis.tdata = next_data; axis.tlast = (last_at == 1);
    while (i < n && budget < 1000) begin
      hs = axis.tready;
      tick(); budget++;
      if (hs) begin
        acc++; i++; next_data++;
        axis.tdata = next_data; axis.tlast = (i + 1 == last_at);
      end
      if (st == 2'd2) break;
    end
    check("offer_budget_ok", budget < 1000, 1'b1);
    axis.tvalid = 1'b0; axis.tlast = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    ask = 1'b1;
    while (cnt != 0 && b < 700) begin tick(); b++; end
    ask = 1'b0;
    tick(); tick();
    check("drain_empty", cnt, 0);
  endtask

  typedef struct {
    int mode; int num; int offer; int last_at; int exp_len; int exp_acc;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int acc, k;
    logic [W-1:0] base;
    logic [W-1:0] got[$];

    vecs[0] = '{mode: 0, num: 4,  offer: 6,  last_at: 0, exp_len: 4, exp_acc: 4};
    vecs[1] = '{mode: 2, num: 0,  offer: 10, last_at: 7, exp_len: 7, exp_acc: 7};
    vecs[2] = '{mode: 3, num: 10, offer: 12, last_at: 5, exp_len: 5, exp_acc: 5};
    vecs[3] = '{mode: 3, num: 3,  offer: 8,  last_at: 6, exp_len: 3, exp_acc: 3};
    vecs[4] = '{mode: 0, num: 1,  offer: 3,  last_at: 1, exp_len: 1, exp_acc: 1};
    vecs[5] = '{mode: 2, num: 9,  offer: 4,  last_at: 1, exp_len: 1, exp_acc: 1};

    rst = 1'b1; flush = 1'b0; ask = 1'b0; mode = 2'd0; num = '0;
    axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = '0; axis.tstrb = '1;
    @(posedge clk); #1;
    tick();
    check("rst_state", st, 0);
    check("rst_count", cnt, 0);
    check("rst_tready", axis.tready, 0);
    rst = 1'b0;
    tick();

    // Mode 0 with NUM == 0 never starts a burst.
    axis.tvalid = 1'b1;
    repeat (4) tick();
    check("num0_idle", st, 0);
    check("num0_count", cnt, 0);
    axis.tvalid = 1'b0;
    tick();

    foreach (vecs[i]) begin
      mode = 2'(vecs[i].mode); num = M'(vecs[i].num);
      offer(vecs[i].offer, vecs[i].last_at, acc);
      check("vec_accepted", acc, vecs[i].exp_acc);
      check("vec_burst_len", blen, vecs[i].exp_len);
      check("vec_count", cnt, vecs[i].exp_acc);
      tick();
      check("vec_back_idle", st, 0);
      drain();
    end

    // Three words then a held read: in order, one cycle after the ask.
    mode = 2'd0; num = M'(3); base = next_data;
    offer(3, 0, acc);
    tick(); tick();
    ask = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) check("read_latency", valid, 1'b1);
      if (valid) got.push_back(dout);
    end
    ask = 1'b0;
    check("read_words", got.size(), 3);
    for (int j = 0; j < got.size(); j++) check("read_order", got[j], base + 64'(j));
    check("read_count", cnt, 0);
    tick();
    check("read_valid_drops", valid, 1'b0);

    // Endless mode fills the FIFO; one pop lets exactly one more beat in.
    mode = 2'd1; num = '0; axis.tvalid = 1'b1;
    k = 0;
    while (k < 600) begin
      axis.tdata = next_data;
      tick();
      next_data++; k++;
    end
    check("full_count", cnt, DEPTH);
    check("full_flag", full, 1'b1);
    check("full_tready", axis.tready, 1'b0);
    ask = 1'b1; tick(); ask = 1'b0;
    repeat (3) tick();
    check("refill_count", cnt, DEPTH);
    flush = 1'b1; axis.tvalid = 1'b0; tick(); flush = 1'b0;
    check("flush_state", st, 3);
    check("flush_count", cnt, 0);
    tick();

    // Flush in the middle of a count-or-TLAST burst keeps the previous burst_len.
    mode = 2'd3; num = M'(10);
    offer(12, 5, acc);
    check("m3_len", blen, 5);
    tick();
    axis.tvalid = 1'b1;
    repeat (4) begin axis.tdata = next_data; next_data++; tick(); end
    axis.tvalid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    check("mflush_state", st, 3);
    check("mflush_count", cnt, 0);
    check("mflush_no_done", done, 1'b0);
    check("mflush_len", blen, 5);
    tick();
    check("mflush_idle", st, 0);

    // Synchronous reset mid-burst with the FIFO about half full.
    mode = 2'd2; axis.tvalid = 1'b1; axis.tlast = 1'b0;
    repeat (258) begin axis.tdata = next_data; next_data++; tick(); end
    ask = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0; ask = 1'b0; axis.tvalid = 1'b0;
    check("mrst_state", st, 0);
    check("mrst_count", cnt, 0);
    check("mrst_len", blen, 0);
    check("mrst_data", dout, 0);
    check("mrst_valid", valid, 1'b0);
    check("mrst_emptyn", emptyn, 1'b0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      axis.tvalid = ($urandom_range(3) != 0);
      axis.tdata  = {$urandom, $urandom};
      axis.tlast  = ($urandom_range(7) == 0);
      ask         = ($urandom_range(2) == 0);
      flush       = ($urandom_range(199) == 0);
      if ($urandom_range(19) == 0) begin
        mode = 2'($urandom_range(3));
        num  = M'($urandom_range(7));
      end
      tick();
    end
    axis.tvalid = 1'b0; flush = 1'b0; ask = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
